conv_pe_array: RTL and testbench

//  Parametrised successor of the layer-1 convolution datapath. NUM_PE filters are

---
 rtl/conv_pe_array.sv | 134 +++++++++++++
 tb/tb_conv_pe_array.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_array.sv
// Parallel convolution PE array: NUM_PE filters MAC each streamed pixel.
// One packed result word per KSIZE-tap window, optional ReLU.
module conv_pe_array #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 16,
  parameter int NUM_PE = 4,
  parameter int ACC_W  = 2*DATA_W+1+$clog2(KSIZE),
  parameter int CNT_W  = 8,
  localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int IDX_W = $clog2(KSIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flt_we,
  input  logic [PE_W-1:0]         flt_pe,
  input  logic [IDX_W-1:0]        flt_idx,
  input  logic [DATA_W-1:0]       flt_data,
  input  logic                    start,
  input  logic [CNT_W-1:0]        win_count,
  input  logic                    relu_en,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_W-1:0]       pix_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_PE*ACC_W-1:0] out_data,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic signed [DATA_W-1:0] flt [NUM_PE][KSIZE];
  logic signed [ACC_W-1:0]  acc [NUM_PE];
  logic signed [ACC_W-1:0]  acc_nx [NUM_PE];
  logic signed [2*DATA_W:0] prod;
  logic [NUM_PE*ACC_W-1:0]  res_nx;
  logic [IDX_W-1:0]         tap;
  logic [CNT_W-1:0]         win_left;
  logic                     relu_q;
  logic                     pix_hs;
  logic                     out_hs;
  logic                     last_pix;
  logic                     flt_ok;
  logic                     go;

  assign pix_ready = (state == RUN);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  assign pix_hs   = pix_valid & pix_ready;
  assign out_hs   = out_valid & out_ready;
  assign last_pix = pix_hs && (tap == IDX_W'(KSIZE-1));
  assign go       = (state == IDLE) && start;
  assign flt_ok   = flt_we && (state == IDLE) &&
                    (int'(flt_pe) < NUM_PE) &&
                    (int'(flt_idx) < KSIZE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last_pix) state_nx = OUT;
      OUT:  if (out_hs)
              state_nx = (win_left <= CNT_W'(1)) ? DONE : RUN;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-PE MAC of the current pixel and ReLU-shaped result word
  always_comb begin
    prod   = '0;
    res_nx = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      prod = $signed({1'b0, pix_data}) * flt[p][tap];
      acc_nx[p] = acc[p] +
        {{(ACC_W-2*DATA_W-1){prod[2*DATA_W]}}, prod};
      res_nx[p*ACC_W +: ACC_W] =
        (relu_q && acc_nx[p][ACC_W-1]) ? '0 : acc_nx[p];
    end
  end

  // Filter register file, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PE; p++)
        for (int k = 0; k < KSIZE; k++)
          flt[p][k] <= '0;
    end else if (flt_ok) begin
      flt[flt_pe][flt_idx] <= flt_data;
    end
  end

  // Accumulators, tap/window counters and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
      tap      <= '0;
      win_left <= '0;
      relu_q   <= 1'b0;
      out_data <= '0;
    end else if (go) begin
      for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
      tap      <= '0;
      win_left <= (win_count == '0) ? CNT_W'(1) : win_count;
      relu_q   <= relu_en;
    end else if (pix_hs) begin
      for (int p = 0; p < NUM_PE; p++) acc[p] <= acc_nx[p];
      tap <= last_pix ? '0 : tap + IDX_W'(1);
      if (last_pix) out_data <= res_nx;
    end else if (out_hs) begin
      for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
      tap      <= '0;
      win_left <= win_left - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_conv_pe_array.sv
// Scoreboard bench for conv_pe_array.
// Directed windows; monitor pops expected words on each result handshake.
module tb_conv_pe_array;

  localparam int NP = 4;
  localparam int K  = 16;
  localparam int AW = 21;
  localparam int OW = NP*AW;
  localparam int SAW = 19;
  localparam int SOW = 3*SAW;

  logic          clk = 0;
  logic          rst;
  logic          flt_we;
  logic [1:0]    flt_pe;
  logic [3:0]    flt_idx;
  logic [7:0]    flt_data;
  logic          start;
  logic [7:0]    win_count;
  logic          relu_en;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          done;

  logic           s_flt_we;
  logic [1:0]     s_flt_pe;
  logic [1:0]     s_flt_idx;
  logic [7:0]     s_flt_data;
  logic           s_start;
  logic [7:0]     s_win_count;
  logic           s_relu_en;
  logic           s_pix_valid;
  logic           s_pix_ready;
  logic [7:0]     s_pix_data;
  logic           s_out_valid;
  logic           s_out_ready;
  logic [SOW-1:0] s_out_data;
  logic           s_busy;
  logic           s_done;

  int n_checks = 0;
  int n_fail   = 0;
  int pix_cnt  = 0;
  int done_cnt = 0;
  int mflt [NP][K];
  int pix_buf [K];
  logic [OW-1:0] exp_q [$];

  always #5 clk = ~clk;

  conv_pe_array dut (
    .clk(clk), .rst(rst),
    .flt_we(flt_we), .flt_pe(flt_pe),
    .flt_idx(flt_idx), .flt_data(flt_data),
    .start(start), .win_count(win_count),
    .relu_en(relu_en),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy), .done(done)
  );

  conv_pe_array #(.NUM_PE(3), .KSIZE(3)) u_small (
    .clk(clk), .rst(rst),
    .flt_we(s_flt_we), .flt_pe(s_flt_pe),
    .flt_idx(s_flt_idx), .flt_data(s_flt_data),
    .start(s_start), .win_count(s_win_count),
    .relu_en(s_relu_en),
    .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .pix_data(s_pix_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data),
    .busy(s_busy), .done(s_done)
  );

  task automatic check(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: count handshakes and pulses, score result words
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid && pix_ready) pix_cnt++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out got=%0h exp=none",
                   out_data);
        end else begin
          check("out_data", 128'(out_data),
                128'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wflt(input int pe, input int idx,
                      input logic [7:0] val);
    flt_we   = 1;
    flt_pe   = 2'(pe);
    flt_idx  = 4'(idx);
    flt_data = val;
    tick();
    flt_we = 0;
    mflt[pe][idx] = int'($signed(val));
  endtask

  task automatic go(input int wc, input bit relu);
    start     = 1;
    win_count = 8'(wc);
    relu_en   = relu;
    tick();
    start = 0;
  endtask

  task automatic push_pix(input int v, input int gap);
    int t;
    repeat ($urandom_range(0, gap)) tick();
    pix_valid = 1;
    pix_data  = 8'(v);
    t = 0;
    @(negedge clk);
    while (!pix_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!pix_ready) check("pix_timeout", 128'(0), 128'(1));
    tick();
    pix_valid = 0;
  endtask

  task automatic do_window(input logic [OW-1:0] e,
                           input int gap);
    exp_q.push_back(e);
    for (int k = 0; k < K; k++) push_pix(pix_buf[k], gap);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 128'(1), 128'(0));
  endtask

  function automatic logic [OW-1:0] model(input bit relu);
    logic [OW-1:0] w;
    logic signed [AW-1:0] t;
    int a;
    w = '0;
    for (int p = 0; p < NP; p++) begin
      a = 0;
      for (int k = 0; k < K; k++) a += pix_buf[k] * mflt[p][k];
      if (relu && a < 0) a = 0;
      t = AW'(a);
      w[p*AW +: AW] = t;
    end
    return w;
  endfunction

  localparam logic [OW-1:0] EXP2 =
    {21'd0, 21'd320, 21'h1FFF60, 21'd160};
  localparam logic [OW-1:0] EXP3 =
    {21'd0, 21'd320, 21'd0, 21'd160};

  initial begin
    logic [OW-1:0] snap;
    int pc, dc, t, cnt;
    rst = 1; flt_we = 0; flt_pe = 0; flt_idx = 0;
    flt_data = 0; start = 0; win_count = 0; relu_en = 0;
    pix_valid = 0; pix_data = 0; out_ready = 1;
    s_flt_we = 0; s_flt_pe = 0; s_flt_idx = 0;
    s_flt_data = 0; s_start = 0; s_win_count = 1;
    s_relu_en = 0; s_pix_valid = 0; s_pix_data = 0;
    s_out_ready = 1;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < K; k++) mflt[p][k] = 0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_pix_ready", 128'(pix_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));

    // Reset in the middle of a run
    tick();
    for (int k = 0; k < K; k++) wflt(0, k, 8'd1);
    go(1, 0);
    for (int k = 0; k < 5; k++) push_pix(10, 0);
    rst = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_pix_ready", 128'(pix_ready), 128'(0));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < K; k++) mflt[p][k] = 0;
    tick();
    for (int k = 0; k < K; k++) pix_buf[k] = 10;
    go(1, 0);
    do_window('0, 0);
    wait_idle();
    check("midrst_done_cnt", 128'(done_cnt), 128'(1));

    // Single window, hand-computed
    tick();
    for (int k = 0; k < K; k++) begin
      wflt(0, k, 8'd1);
      wflt(1, k, 8'hFF);
      wflt(2, k, 8'd2);
      wflt(3, k, 8'd0);
    end
    dc = done_cnt;
    go(1, 0);
    do_window(EXP2, 0);
    wait_idle();
    check("single_done", 128'(done_cnt - dc), 128'(1));

    // ReLU
    tick();
    dc = done_cnt;
    go(1, 1);
    do_window(EXP3, 1);
    wait_idle();
    check("relu_done", 128'(done_cnt - dc), 128'(1));

    // Backpressure with illegal start and filter write in OUT
    tick();
    out_ready = 0;
    dc = done_cnt;
    go(1, 0);
    do_window(EXP2, 0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid", 128'(out_valid), 128'(1));
    snap = out_data;
    pc = pix_cnt;
    pix_valid = 1; pix_data = 8'd7;
    start = 1; win_count = 8'd5;
    flt_we = 1; flt_pe = 0; flt_idx = 0; flt_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", 128'(out_data), 128'(snap));
      check("bp_pix_ready", 128'(pix_ready), 128'(0));
    end
    pix_valid = 0; start = 0; flt_we = 0;
    check("bp_no_pix", 128'(pix_cnt), 128'(pc));
    out_ready = 1;
    wait_idle();
    check("bp_done", 128'(done_cnt - dc), 128'(1));
    repeat (3) tick();
    check("start_in_out_ignored", 128'(busy), 128'(0));

    // Filter write during RUN is dropped
    dc = done_cnt;
    go(1, 0);
    flt_we = 1; flt_pe = 0; flt_idx = 0; flt_data = 8'd99;
    do_window(EXP2, 1);
    flt_we = 0;
    wait_idle();
    check("we_run_done", 128'(done_cnt - dc), 128'(1));

    // Multi-window with random filters and gaps
    tick();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < K; k++)
        wflt(p, k, 8'($urandom_range(0, 255)));
    pc = pix_cnt;
    dc = done_cnt;
    go(3, 0);
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < K; k++)
        pix_buf[k] = int'($urandom_range(0, 255));
      do_window(model(0), 3);
    end
    wait_idle();
    check("multi_pix", 128'(pix_cnt - pc), 128'(48));
    check("multi_done", 128'(done_cnt - dc), 128'(1));

    // win_count = 0 runs one window, with ReLU on random data
    tick();
    pc = pix_cnt;
    dc = done_cnt;
    go(0, 1);
    for (int k = 0; k < K; k++)
      pix_buf[k] = int'($urandom_range(0, 255));
    do_window(model(1), 2);
    wait_idle();
    check("wc0_pix", 128'(pix_cnt - pc), 128'(16));
    check("wc0_done", 128'(done_cnt - dc), 128'(1));

    // Out-of-range filter select on a 3-PE, 3-tap array
    tick();
    s_flt_we = 1; s_flt_pe = 2'd3; s_flt_idx = 2'd0;
    s_flt_data = 8'd5;
    tick();
    s_flt_pe = 2'd0; s_flt_idx = 2'd3;
    tick();
    s_flt_pe = 2'd1; s_flt_idx = 2'd1; s_flt_data = 8'd2;
    tick();
    s_flt_we = 0;
    s_start = 1;
    tick();
    s_start = 0;
    s_pix_valid = 1; s_pix_data = 8'd4;
    cnt = 0; t = 0;
    while (cnt < 3 && t < 50) begin
      @(negedge clk);
      if (s_pix_valid && s_pix_ready) cnt++;
      t++;
      tick();
    end
    s_pix_valid = 0;
    check("small_pix", 128'(cnt), 128'(3));
    t = 0;
    @(negedge clk);
    while (!s_out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("small_oor", 128'(s_out_data),
          128'({19'd0, 19'd8, 19'd0}));
    repeat (4) tick();
    check("small_idle", 128'(s_busy), 128'(0));

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
